// File: rtl/sprint_timer_ctrl.sv
// Sprint stopwatch controller: start/stop/clear keys, 0.01 s resolution,
// counts 00.00 .. 99.99 and saturates into an overflow state.
module sprint_timer_ctrl #(
  parameter int TICK_DIV = 1000000
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic       I_key_ss,
  input  logic       I_key_clr,
  output logic [6:0] O_sec,
  output logic [6:0] O_csec,
  output logic       O_running,
  output logic       O_overflow
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, FULL} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [6:0]    sec_q, sec_d;
  logic [6:0]    csec_q, csec_d;
  logic          ss_prev_q, clr_prev_q;
  logic          run_q, ovf_q;
  logic          ss_ev, clr_ev, tick;

  // Rising-edge press detection; previous levels preset high so a key held
  // through reset has to be released before it counts.
  assign ss_ev  = I_key_ss  & ~ss_prev_q;
  assign clr_ev = I_key_clr & ~clr_prev_q;
  assign tick   = (presc_q == PMAX);

  // Next state, prescaler and time; clear wins over everything else.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    sec_d   = sec_q;
    csec_d  = csec_q;
    if (clr_ev) begin
      state_d = IDLE;
      presc_d = '0;
      sec_d   = '0;
      csec_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ss_ev) begin
            state_d = RUN;
            presc_d = '0;
          end
        end
        RUN: begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          // A due advance lands first; a stop on the same edge then freezes
          // the advanced value. Saturation takes precedence over stopping.
          if (ss_ev) state_d = HOLD;
          if (tick) begin
            if (sec_q == 7'd99 && csec_q == 7'd99) begin
              state_d = FULL;
            end else if (csec_q == 7'd99) begin
              csec_d = '0;
              sec_d  = sec_q + 7'd1;
            end else begin
              csec_d = csec_q + 7'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State, time and registered status outputs.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      sec_q      <= '0;
      csec_q     <= '0;
      ss_prev_q  <= 1'b1;
      clr_prev_q <= 1'b1;
      run_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      csec_q     <= csec_d;
      ss_prev_q  <= I_key_ss;
      clr_prev_q <= I_key_clr;
      run_q      <= (state_d == RUN);
      ovf_q      <= (state_d == FULL);
    end
  end

  assign O_sec      = sec_q;
  assign O_csec     = csec_q;
  assign O_running  = run_q;
  assign O_overflow = ovf_q;

endmodule

// File: doc/sprint_timer_ctrl.md
SPRINT_TIMER_CTRL -- requirements
Module: sprint_timer_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000000, meaning I_clk cycles per 0.01 s tick (legal range 2 or more).
REQ-002 SHALL have port I_clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-003 SHALL have port I_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port I_key_ss, input, 1 bit: debounced start/stop key level, high while pressed.
REQ-005 SHALL have port I_key_clr, input, 1 bit: debounced clear key level, high while pressed.
REQ-006 SHALL have port O_sec, output, 7 bits: elapsed whole seconds, binary 0..99.
REQ-007 SHALL have port O_csec, output, 7 bits: elapsed centiseconds, binary 0..99.
REQ-008 SHALL have port O_running, output, 1 bit: high only in state RUN.
REQ-009 SHALL have port O_overflow, output, 1 bit: high only in state FULL.

Function
REQ-010 SHALL detect a press event per key when the current level is 1 and the registered previous level is 0; exactly one event per press regardless of hold length.
REQ-011 SHALL implement states IDLE, RUN, HOLD, FULL, all registered; every output SHALL be registered.
REQ-012 SHALL make these transitions on the clock edge ending the event cycle:
- IDLE + ss event -> RUN
- RUN + ss event -> HOLD
- HOLD + ss event -> no change; the result stays frozen
- any state + clr event -> IDLE
REQ-013 SHALL give a clr event priority over an ss event in the same cycle; the result is IDLE with time 0.
REQ-014 SHALL, on entering IDLE, set O_sec, O_csec and the prescaler to 0.
REQ-015 SHALL clear the prescaler to 0 on the IDLE->RUN edge.
REQ-016 SHALL, in RUN, increment the prescaler each cycle; when it equals TICK_DIV-1, it SHALL wrap to 0 and the time SHALL advance one centisecond on that same edge.
- Result: the first advance occurs exactly TICK_DIV cycles after entering RUN.
REQ-017 SHALL advance the time as follows:
- O_csec 99 -> 0 with O_sec +1
- otherwise O_csec +1
- O_sec never exceeds 99
REQ-018 SHALL, when an advance is due at 99.99 in RUN, hold 99.99 and enter FULL; FULL ignores ss events and leaves only on a clr event or reset.
REQ-019 SHALL give an ss event in RUN on the same edge as a due advance this order: the advance applies first, then the state becomes HOLD.
REQ-020 SHALL freeze the prescaler and time outside RUN, except for the clears in REQ-014.
REQ-021 SHALL use prescaler width ceil(log2(TICK_DIV)) bits; the time registers SHALL never hold values above 99.

Reset
REQ-022 SHALL, with I_rst=1 at a clock edge, set state IDLE, O_sec=0, O_csec=0, O_running=0, O_overflow=0 and prescaler 0, overriding every other input.
REQ-023 SHALL load both previous-level registers with 1 during reset, so a key held through reset produces no event until it is released and pressed again.
REQ-024 SHALL apply reset asserted mid-RUN at the next edge with no residual count.

Verification (TICK_DIV=4)
REQ-025 SHALL cover start and count: reset, then ss pulse -> O_running=1 next edge; after 4 cycles O_csec=1; after 400 cycles O_sec=1, O_csec=0.
REQ-026 SHALL cover stop and hold: ss press in RUN at 00.37 -> O_running=0, 00.37 held; ss held 50 cycles then pressed again -> still 00.37, HOLD.
REQ-027 SHALL cover wrap and saturate: run to 99.99 -> the next due tick gives O_overflow=1, 99.99 held; ss press -> no change; clr press -> 00.00, IDLE.
REQ-028 SHALL cover simultaneous keys: ss and clr rise in the same cycle during RUN -> IDLE, 00.00, O_running=0.
REQ-029 SHALL cover a key held through reset: I_key_ss=1 across I_rst -> no start until the key goes low then high again.
REQ-030 SHALL cover coincident stop and tick: ss event on the cycle prescaler=3 at 00.09 -> 00.10 shown, state HOLD.
